imem_boot_loader: RTL and testbench

Loads a program image into the core's instruction memory from a byte stream (UART RX side) and holds the core in reset until the image is complete and verified. It drives the instruction-memory write port that the pipeline's fetch stage reads. It is the synthesizable replacement for simulation-time `HEX_FILE` preloading. It releases the core only after a well-formed image has been fully written.

---
 rtl/boot_pkg.sv | 20 ++
 rtl/boot_word_packer.sv | 38 +++
 rtl/imem_boot_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Config macro: IMEM_BOOT_CSUM_EN (enables the trailing checksum byte).
package boot_pkg;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;
  localparam int         LEN_W      = 16;

  typedef enum logic [2:0] {
    ST_WAIT_MAGIC,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
`ifdef IMEM_BOOT_CSUM_EN
    ST_CSUM,
`endif
    ST_RUN,
    ST_ERR
  } boot_state_e;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles four little-endian bytes into one 32-bit word.
// Config macro: IMEM_BOOT_CSUM_EN (not used in this file).
module boot_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;

  // Shift each byte in from the top; the 4th byte completes the word.
  always_comb begin
    idx_d      = idx_q;
    buf_d      = buf_q;
    word_valid = byte_valid && (idx_q == 2'd3);
    word       = {byte_data, buf_q};
    if (byte_valid) begin
      idx_d = idx_q + 2'd1;
      buf_d = {byte_data, buf_q[23:8]};
    end
  end

  // Byte index and partial-word buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      buf_q <= 24'd0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed program image into IMEM and releases the core.
// Config macro: IMEM_BOOT_CSUM_EN (require and verify checksum byte).
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  boot_state_e       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              rx_ready_q, rx_ready_d;
`ifdef IMEM_BOOT_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept;
  logic [LEN_W-1:0]  len_full;
  logic              oversize;
  logic [ADDR_W:0]   words_inc;
  logic              pk_valid;
  logic [31:0]       pk_word;

  assign accept    = rx_valid & rx_ready_q;
  assign len_full  = {rx_data, len_lo_q};
  assign oversize  = len_full > LEN_W'(IMEM_DEPTH);
  assign words_inc = words_q + {{ADDR_W{1'b0}}, 1'b1};

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (accept && (state_q == ST_DATA)),
    .byte_data  (rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  // Frame parser: next state, counters, write port, status outputs.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    words_d  = words_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef IMEM_BOOT_CSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      ST_WAIT_MAGIC: begin
        if (accept && rx_data == BOOT_MAGIC)
          state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = len_full[ADDR_W:0];
          if (oversize)
            state_d = ST_ERR;
          else if (len_full == '0)
`ifdef IMEM_BOOT_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_RUN;
`endif
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
`ifdef IMEM_BOOT_CSUM_EN
        if (accept)
          csum_d = csum_q + rx_data;
`endif
        if (pk_valid) begin
          we_d    = 1'b1;
          addr_d  = words_q[ADDR_W-1:0];
          wdata_d = pk_word;
          words_d = words_inc;
          if (words_inc == len_q)
`ifdef IMEM_BOOT_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_RUN;
`endif
        end
      end
`ifdef IMEM_BOOT_CSUM_EN
      ST_CSUM: begin
        if (accept)
          state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
      end
`endif
      default: state_d = state_q;
    endcase
    done_d      = (state_d == ST_RUN);
    cpu_rst_n_d = (state_d == ST_RUN);
    error_d     = (state_d == ST_ERR);
    rx_ready_d  = (state_d != ST_RUN);
  end

  // State and registered outputs; rst aborts any load in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_MAGIC;
      len_lo_q    <= 8'd0;
      len_q       <= '0;
      words_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rx_ready_q  <= 1'b1;
`ifdef IMEM_BOOT_CSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      words_q     <= words_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      error_q     <= error_d;
      rx_ready_q  <= rx_ready_d;
`ifdef IMEM_BOOT_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: random framed images.
// Config macro: IMEM_BOOT_CSUM_EN (bench follows the same define).
module tb_imem_boot_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
`ifdef IMEM_BOOT_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_boot_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            c;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] stim_words[$];
  logic [7:0]  stim_garb[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: addr %h data %h", imem_addr, imem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("we_addr", 32'(imem_addr), 32'(e.a));
        chk("we_data", imem_wdata, e.d);
        chk("we_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  // Drives one byte; c is the cycle in which a write for it would show.
  task automatic send_byte(input logic [7:0] b, output int c);
    @(negedge clk);
    chk("rx_ready_stall", 32'(rx_ready), 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    c        = cyc + 1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference: sends a frame and predicts writes and final status.
  task automatic run_frame(input int len, input bit bad, input bit do_rst);
    int          c;
    logic [15:0] l;
    logic [7:0]  sum;
    logic [31:0] w;
    bit          bad_eff;
    exp_t        e;
    l       = len[15:0];
    sum     = 8'd0;
    bad_eff = bad && CSUM_EN;
    if (do_rst) reset_dut();
    foreach (stim_garb[i]) send_byte(stim_garb[i], c);
    send_byte(8'hA5, c);
    send_byte(l[7:0], c);
    send_byte(l[15:8], c);
    if (len > DEPTH) begin
      @(negedge clk);
      chk("ovf_error", 32'(error), 32'd1);
      chk("ovf_done", 32'(done), 32'd0);
      chk("ovf_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("ovf_rx_ready", 32'(rx_ready), 32'd1);
      chk("ovf_words", 32'(words_loaded), 32'd0);
      for (int k = 0; k < 6; k++) send_byte(8'($urandom), c);
      @(negedge clk);
      chk("ovf_error_sticky", 32'(error), 32'd1);
      return;
    end
    for (int i = 0; i < len; i++) begin
      w = (i < stim_words.size()) ? stim_words[i] : $urandom;
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], c);
        sum = sum + w[8*k +: 8];
      end
      e.a = AW'(i);
      e.d = w;
      e.c = c;
      exp_q.push_back(e);
    end
    if (CSUM_EN) send_byte(bad_eff ? sum + 8'd1 : sum, c);
    @(negedge clk);
    chk("fin_done", 32'(done), bad_eff ? 32'd0 : 32'd1);
    chk("fin_cpu_rst_n", 32'(cpu_rst_n), bad_eff ? 32'd0 : 32'd1);
    chk("fin_error", 32'(error), bad_eff ? 32'd1 : 32'd0);
    chk("fin_rx_ready", 32'(rx_ready), bad_eff ? 32'd1 : 32'd0);
    chk("fin_words", 32'(words_loaded), 32'(len));
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("hold_words", 32'(words_loaded), 32'(len));
    chk("hold_done", 32'(done), bad_eff ? 32'd0 : 32'd1);
  endtask

  task automatic rand_garb(input int n);
    logic [7:0] b;
    stim_garb = {};
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      stim_garb.push_back(b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    exp_t e;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    stim_words = '{32'h00000293, 32'h00B00313};
    stim_garb  = {};
    run_frame(2, 1'b0, 1'b1);
    stim_garb  = '{8'h00, 8'hFF, 8'h5A};
    run_frame(2, 1'b0, 1'b1);
    run_frame(2, 1'b1, 1'b1);
    stim_garb  = {};
    run_frame(32'h0401, 1'b0, 1'b1);
    run_frame(32'hFFFF, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1'b1);

    // Abort after 5 data bytes, then reload from address 0.
    reset_dut();
    send_byte(8'hA5, c);
    send_byte(8'h02, c);
    send_byte(8'h00, c);
    for (int k = 0; k < 4; k++) send_byte(stim_words[0][8*k +: 8], c);
    e.a = '0;
    e.d = stim_words[0];
    e.c = c;
    exp_q.push_back(e);
    send_byte(8'h13, c);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    run_frame(2, 1'b0, 1'b0);

    stim_words = {};
    for (int n = 0; n < 10; n++) begin
      rand_garb($urandom_range(0, 3));
      run_frame($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b1);
    end
    stim_garb = {};
    run_frame(DEPTH, 1'b0, 1'b1);
    run_frame(DEPTH + 1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
